freq_meter_ranged: RTL and testbench
====================================

Name: freq_meter_ranged

Overview:
Reciprocal-free, gated frequency meter fully synchronous to Clk, the successor of the single-range meter. It counts rising edges of the asynchronous Fxin over a selectable gate window (three decades), saturates at parametrised widths and converts the result to packed BCD with a sequential converter. It publishes the binary result, BCD result, range code and over-range flag atomically, with a one-cycle Valid strobe. It sits between the input conditioning and the seven-segment display driver.

Parameters:
GATE_CYCLES, 100000000, Clk cycles in the longest (range 0) gate window; must be divisible by 100; GATE_CYCLES/100 >= CNT_W+4
CNT_W, 14, edge counter and binary result width
BCD_DIGITS, 4, packed BCD digits on Frequency

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active high
Fxin  in  1  asynchronous measured signal; meaningful up to Clk/4
Gate_Sel  in  2  gate window select: 0 = GATE_CYCLES, 1 = /10, 2 = /100, 3 = treated as 2
Frequency  out  4*BCD_DIGITS  packed BCD result, digit 0 in LSBs
Binary_Out  out  CNT_W  saturated binary edge count
Range  out  2  Gate_Sel value (3 mapped to 2) in force for the published window
Over_Range  out  1  count saturated at 2^CNT_W-1, or value > 10^BCD_DIGITS-1
Valid  out  1  one-cycle strobe when the outputs above update

Behaviour:
- Single clock Clk; reset Rst is synchronous, active-high.
- Reset: all outputs 0. Gate timer, edge counter, sync flops, converter state and the first-window flag are 0. Reset mid-window or mid-conversion aborts the window or conversion. No Valid is issued for it.
- Input path: Fxin passes through 2-flop synchroniser s1,s2 and then delay flop s3. rise = s2 & ~s3. A Fxin edge reaches the counter 3 cycles later.
- Gate timer counts 0..G-1, G = GATE_CYCLES/10^sel. sel is sampled into an internal register only on the cycle the timer wraps to 0, and on the first cycle after reset. A Gate_Sel change mid-window takes effect from the next window.
- Edge counter increments on rise and saturates at 2^CNT_W-1, setting sticky sat. The terminal cycle (timer = G-1) includes a rise on that same cycle in the closing window.
- On the terminal cycle: count and sat latch into the result holding register, along with the window's sel. Counter and sat clear, so the first cycle of the next window starts from 0 (+1 if rise). The timer restarts with no dead cycles.
- First window after reset is discarded: no latch, no conversion, no Valid. This avoids a partial window and a spurious edge at reset release.
- Conversion: start pulses the cycle after the terminal cycle. The converter (shift-add-3) takes CNT_W cycles.
  - If the value > 10^BCD_DIGITS-1, BCD output forces all digits to 9 and Over_Range = 1.
  - Over_Range = sat OR BCD overflow.
- Publication: Frequency, Binary_Out, Range and Over_Range update together with Valid = 1 exactly CNT_W+2 cycles after the terminal cycle. Outputs hold until the next publication.
- Conversion always finishes before the next terminal cycle (parameter constraint), so no overlap handling is needed. Sanity check: assertion if start arrives while busy.
- Fxin constant: result 0, Valid still issued each window.

Decomposition:
- Package freq_meter_pkg:
  - gate select constants GATE_SEL_X1/X10/X100
  - function gate_len(base, sel)
  - function bcd_max(digits) = 10^digits-1
  - localparam check helpers for the GATE_CYCLES constraint
- Sub-module bcd_seq_converter: ports Clk, Rst, Start, Bin[CNT_W], Bcd[4*BCD_DIGITS], Ovf, Done. One busy FSM with states IDLE, SHIFT, DONE, and a shift counter.

Test Plan:
1. GATE_CYCLES=2000, Gate_Sel=0, Fxin period 8 Clk, 2 windows -> first window silent; second gives Binary_Out=250, Frequency=16'h0250, Range=0, Over_Range=0, Valid exactly CNT_W+2=16 cycles after the terminal cycle.
2. Gate_Sel=1 (G=200), Fxin period 4 Clk -> Binary_Out=50, Frequency=16'h0050, Range=1, Valid every 200 cycles.
3. BCD_DIGITS=2, G=2000, Fxin period 4 Clk -> Binary_Out=500, Frequency=8'h99, Over_Range=1. With CNT_W=6 -> Binary_Out=63, Over_Range=1.
4. Rst held 1 cycle at timer=1000 of a window -> all outputs 0 next cycle. No Valid for that window or the next full window. Correct result (250 at period 8) on the second window after release.
5. Gate_Sel 0->2 at timer=300 -> that window completes at 2000 cycles with Range=0. Following windows are 20 cycles; Fxin period 4 gives Binary_Out=5, Frequency=16'h0005, Range=2.
6. Fxin held low for 3 windows -> Frequency=0, Over_Range=0, Valid once per window.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the
// ranged frequency meter and its BCD converter.
package freq_meter_pkg;

    // Gate window select codes; code 3 is folded onto the x100 range.
    localparam logic [1:0] GATE_SEL_X1   = 2'd0;
    localparam logic [1:0] GATE_SEL_X10  = 2'd1;
    localparam logic [1:0] GATE_SEL_X100 = 2'd2;

    // Busy FSM of the sequential binary-to-BCD converter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Fold the unused select code onto the shortest window.
    function automatic logic [1:0] sel_norm(input logic [1:0] sel);
        return (sel == 2'd3) ? GATE_SEL_X100 : sel;
    endfunction

    // Window length in clock cycles for a given select code.
    function automatic int unsigned gate_len(input int unsigned base, input logic [1:0] sel);
        case (sel_norm(sel))
            GATE_SEL_X1:  return base;
            GATE_SEL_X10: return base / 10;
            default:      return base / 100;
        endcase
    endfunction

    // Largest value representable in the given number of BCD digits.
    function automatic logic [63:0] bcd_max(input int unsigned digits);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    // The shortest window must leave room for a full conversion.
    function automatic bit gate_cycles_ok(input int unsigned base, input int unsigned cnt_w);
        return ((base % 100) == 0) && ((base / 100) >= (cnt_w + 4));
    endfunction

endpackage

// File: rtl/freq_meter_ranged_bcd.sv
// Sequential shift-add-3 binary-to-BCD converter. The load cycle also
// performs the first shift, so a conversion occupies CNT_W clock edges
// and Done is high for one cycle with Bcd/Ovf stable.
module bcd_seq_converter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W      = 14,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic [CNT_W-1:0]        Bin,
    output logic [4*BCD_DIGITS-1:0] Bcd,
    output logic                    Ovf,
    output logic                    Done
);

    localparam int          BCD_W   = 4 * BCD_DIGITS;
    localparam int          SC_W    = $clog2(CNT_W + 1);
    localparam logic [63:0] BCD_MAX = bcd_max(BCD_DIGITS);

    conv_state_e       state_q, state_d;
    logic [BCD_W-1:0]  bcd_q;
    logic [CNT_W-1:0]  sh_q;
    logic [SC_W-1:0]   cnt_q;
    logic              ovf_q;

    // One double-dabble step: adjust digits >= 5, then shift left by one.
    function automatic logic [BCD_W+CNT_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                                       input logic [CNT_W-1:0] s);
        logic [BCD_W-1:0] adj;
        adj = b;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], s, 1'b0};
    endfunction

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Done strobe.
    always_comb begin
        state_d = state_q;
        Done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = (CNT_W == 1) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == SC_W'(CNT_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift datapath: load plus first step on Start, one step per SHIFT cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bcd_q <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && Start) begin
            {bcd_q, sh_q} <= dd_step('0, Bin);
            cnt_q         <= SC_W'(1);
            ovf_q         <= (64'(Bin) > BCD_MAX);
        end else if (state_q == SHIFT) begin
            {bcd_q, sh_q} <= dd_step(bcd_q, sh_q);
            cnt_q         <= cnt_q + SC_W'(1);
        end
    end

    assign Bcd = ovf_q ? {BCD_DIGITS{4'h9}} : bcd_q;
    assign Ovf = ovf_q;

    // A new conversion must never be requested while one is in flight.
    a_start_when_idle: assert property (@(posedge Clk) disable iff (Rst) Start |-> (state_q == IDLE));

endmodule

// File: rtl/freq_meter_ranged.sv
// Gated, three-range frequency meter. Counts synchronised rising edges of
// Fxin over a selectable window, latches the saturated count at the end of
// each window and publishes binary, BCD, range and over-range together with
// a one-cycle Valid, CNT_W+2 cycles after the window's last cycle.
module freq_meter_ranged
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 14,
    parameter int BCD_DIGITS  = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Fxin,
    input  logic [1:0]              Gate_Sel,
    output logic [4*BCD_DIGITS-1:0] Frequency,
    output logic [CNT_W-1:0]        Binary_Out,
    output logic [1:0]              Range,
    output logic                    Over_Range,
    output logic                    Valid
);

    localparam int               BCD_W     = 4 * BCD_DIGITS;
    localparam int               TMR_W     = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] LAST_X1   = TMR_W'(gate_len(GATE_CYCLES, GATE_SEL_X1) - 1);
    localparam logic [TMR_W-1:0] LAST_X10  = TMR_W'(gate_len(GATE_CYCLES, GATE_SEL_X10) - 1);
    localparam logic [TMR_W-1:0] LAST_X100 = TMR_W'(gate_len(GATE_CYCLES, GATE_SEL_X100) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               GATE_OK   = gate_cycles_ok(GATE_CYCLES, CNT_W);

    logic             s1, s2, s3, rise;
    logic [TMR_W-1:0] timer_q, last;
    logic [1:0]       sel_q, sel_in;
    logic             first_done_q, terminal;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             sat_q, sat_nx;
    logic [CNT_W-1:0] res_bin_q;
    logic             res_sat_q;
    logic [1:0]       res_range_q;
    logic             start_q;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_ovf, conv_done;

    assign sel_in   = sel_norm(Gate_Sel);
    assign rise     = s2 & ~s3;
    assign terminal = (timer_q == last);

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= Fxin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Last timer value of the window for the select in force.
    always_comb begin
        case (sel_q)
            GATE_SEL_X1:  last = LAST_X1;
            GATE_SEL_X10: last = LAST_X10;
            default:      last = LAST_X100;
        endcase
    end

    // Edge count including this cycle's rise, held at the saturation value.
    always_comb begin
        cnt_nx = cnt_q;
        if (rise && (cnt_q != CNT_MAX)) begin
            cnt_nx = cnt_q + CNT_W'(1);
        end
        sat_nx = sat_q | (cnt_nx == CNT_MAX);
    end

    // Gate timer; select is captured on wrap and on the first cycle after reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            timer_q      <= '0;
            sel_q        <= GATE_SEL_X1;
            first_done_q <= 1'b0;
        end else if (terminal) begin
            timer_q      <= '0;
            sel_q        <= sel_in;
            first_done_q <= 1'b1;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
            if (timer_q == '0 && !first_done_q) begin
                sel_q <= sel_in;
            end
        end
    end

    // Edge counter with sticky saturation, cleared at each window end.
    always_ff @(posedge Clk) begin
        if (Rst || terminal) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nx;
            sat_q <= sat_nx;
        end
    end

    // Result holding register and conversion start; the first window is dropped.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            res_bin_q   <= '0;
            res_sat_q   <= 1'b0;
            res_range_q <= 2'd0;
            start_q     <= 1'b0;
        end else begin
            start_q <= terminal && first_done_q;
            if (terminal && first_done_q) begin
                res_bin_q   <= cnt_nx;
                res_sat_q   <= sat_nx;
                res_range_q <= sel_q;
            end
        end
    end

    bcd_seq_converter #(
        .CNT_W      (CNT_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_conv (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (start_q),
        .Bin   (res_bin_q),
        .Bcd   (conv_bcd),
        .Ovf   (conv_ovf),
        .Done  (conv_done)
    );

    // Publish all result fields together with a one-cycle Valid.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Frequency  <= '0;
            Binary_Out <= '0;
            Range      <= 2'd0;
            Over_Range <= 1'b0;
            Valid      <= 1'b0;
        end else begin
            Valid <= conv_done;
            if (conv_done) begin
                Frequency  <= conv_bcd;
                Binary_Out <= res_bin_q;
                Range      <= res_range_q;
                Over_Range <= res_sat_q | conv_ovf;
            end
        end
    end

    // Shortest window must hold a full conversion.
    a_gate_cfg: assert property (@(posedge Clk) GATE_OK);

endmodule

// File: tb/tb_freq_meter_ranged.sv
// Randomised bench for freq_meter_ranged: a window-level reference model
// predicts each publication, a monitor compares them as Valid appears.
module tb_freq_meter_ranged;

    localparam int GATE_CYCLES = 2000;
    localparam int CNT_W       = 8;
    localparam int BCD_DIGITS  = 2;
    localparam int BCD_W       = 4 * BCD_DIGITS;
    localparam int EXP_W       = 32 + 2 + 1 + CNT_W + BCD_W;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int BCD_MAX     = (10 ** BCD_DIGITS) - 1;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             fxin = 1'b0;
    logic [1:0]       gate_sel = 2'd0;
    logic [BCD_W-1:0] frequency;
    logic [CNT_W-1:0] binary_out;
    logic [1:0]       range_o;
    logic             over_range;
    logic             valid;

    freq_meter_ranged #(
        .GATE_CYCLES (GATE_CYCLES),
        .CNT_W       (CNT_W),
        .BCD_DIGITS  (BCD_DIGITS)
    ) dut (
        .Clk        (clk),
        .Rst        (rst),
        .Fxin       (fxin),
        .Gate_Sel   (gate_sel),
        .Frequency  (frequency),
        .Binary_Out (binary_out),
        .Range      (range_o),
        .Over_Range (over_range),
        .Valid      (valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [EXP_W-1:0] exp_q[$];

    // Fxin generator controls: 0 = hold level, 1 = periodic, 2 = random hold times.
    int   fx_mode  = 0;
    logic fx_level = 1'b0;
    int   fx_per   = 8;
    int   fx_ph    = 0;
    int   fx_hold  = 0;

    function automatic int glen(input logic [1:0] s);
        if (s == 2'd0) return GATE_CYCLES;
        else if (s == 2'd1) return GATE_CYCLES / 10;
        else return GATE_CYCLES / 100;
    endfunction

    function automatic logic [1:0] rmap(input logic [1:0] s);
        return (s == 2'd3) ? 2'd2 : s;
    endfunction

    // Expected publication for a window that saw 'edges' rising edges.
    function automatic logic [EXP_W-1:0] expect_window(input int edges, input logic [1:0] rng, input int due);
        int               cnt;
        int               v;
        logic             sat;
        logic             bovf;
        logic [BCD_W-1:0] bcd;
        logic [31:0]      due_v;
        logic [CNT_W-1:0] bin_v;
        cnt  = (edges >= CNT_MAX) ? CNT_MAX : edges;
        sat  = (edges >= CNT_MAX);
        bovf = (cnt > BCD_MAX);
        v    = cnt;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            bcd[4*d +: 4] = bovf ? 4'd9 : 4'(v % 10);
            v = v / 10;
        end
        due_v = 32'(due);
        bin_v = CNT_W'(cnt);
        return {due_v, rng, sat | bovf, bin_v, bcd};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_frequency"},  64'(frequency),  64'd0);
        check({tag, "_binary_out"}, 64'(binary_out), 64'd0);
        check({tag, "_range"},      64'(range_o),    64'd0);
        check({tag, "_over_range"}, 64'(over_range), 64'd0);
        check({tag, "_valid"},      64'(valid),      64'd0);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Fxin driver, changes only on the falling edge.
    initial begin : fx_drive
        forever begin
            @(negedge clk);
            case (fx_mode)
                0: fxin = fx_level;
                1: begin
                    fxin  = (fx_ph < fx_per / 2);
                    fx_ph = (fx_ph + 1 >= fx_per) ? 0 : fx_ph + 1;
                end
                default: begin
                    if (fx_hold <= 0) begin
                        fxin    = ~fxin;
                        fx_hold = $urandom_range(2, 6);
                    end else begin
                        fx_hold--;
                    end
                end
            endcase
        end
    end

    // Reference model: windows, edge attribution and expected publications.
    int          m_cyc   = 0;
    int          m_edges = 0;
    int          m_wend  = -1;
    logic        m_first = 1'b1;
    logic        m_prev  = 1'b0;
    logic [1:0]  m_sel   = 2'd0;
    int          rise_q[$];

    initial begin : model
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cyc   = 0;
                m_edges = 0;
                m_wend  = -1;
                m_first = 1'b1;
                m_prev  = 1'b0;
                rise_q.delete();
                exp_q.delete();
            end else begin
                // An input rise seen in cycle c is counted in the window holding cycle c+2.
                if (fxin && !m_prev) rise_q.push_back(m_cyc + 2);
                m_prev = fxin;
                while (rise_q.size() != 0 && rise_q[0] == m_cyc) begin
                    void'(rise_q.pop_front());
                    m_edges++;
                end
                if (m_cyc == 0) begin
                    m_sel  = rmap(gate_sel);
                    m_wend = glen(gate_sel) - 1;
                end
                if (m_cyc == m_wend) begin
                    if (!m_first) exp_q.push_back(expect_window(m_edges, m_sel, m_cyc + CNT_W + 2));
                    m_first = 1'b0;
                    m_edges = 0;
                    m_sel   = rmap(gate_sel);
                    m_wend  = m_cyc + glen(gate_sel);
                end
                m_cyc++;
            end
        end
    end

    // Monitor: compare every publication, flag missing or unexpected Valid.
    initial begin : monitor
        logic [EXP_W-1:0] e;
        logic [31:0]      e_due;
        logic [1:0]       e_rng;
        logic             e_ovr;
        logic [CNT_W-1:0] e_bin;
        logic [BCD_W-1:0] e_bcd;
        forever begin
            @(negedge clk);
            if (valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid cycle=%0d bin=%0d required=no publication", m_cyc, binary_out);
                end else begin
                    e = exp_q.pop_front();
                    {e_due, e_rng, e_ovr, e_bin, e_bcd} = e;
                    if (32'(m_cyc) !== e_due || range_o !== e_rng || over_range !== e_ovr ||
                        binary_out !== e_bin || frequency !== e_bcd) begin
                        n_fail++;
                        $display("FAIL publish actual cycle=%0d bin=%0d bcd=%0h range=%0d over=%0d required cycle=%0d bin=%0d bcd=%0h range=%0d over=%0d",
                                 m_cyc, binary_out, frequency, range_o, over_range,
                                 e_due, e_bin, e_bcd, e_rng, e_ovr);
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q[0];
                {e_due, e_rng, e_ovr, e_bin, e_bcd} = e;
                if (32'(m_cyc) > e_due) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_valid actual=none by cycle %0d required=valid at cycle %0d", m_cyc, e_due);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin : stimulus
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        check_zero("reset");

        // Range 0, period 8: first window silent, then 250 edges per window.
        fx_mode = 1; fx_per = 8; fx_ph = 0;
        run(3 * GATE_CYCLES + 50);

        // Range 1, period 4: switch takes effect from the next window.
        gate_sel = 2'd1; fx_per = 4;
        run(GATE_CYCLES + 6 * 200);

        // Reset in the middle of a long window.
        gate_sel = 2'd0; fx_per = 8;
        run(1000 + $urandom_range(0, 500));
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        check_zero("mid_reset");
        run(3 * GATE_CYCLES + 100);

        // Select change partway through a range-0 window.
        run(300);
        gate_sel = 2'd2; fx_per = 4;
        run(GATE_CYCLES + 10 * 20);

        // Randomised phases: select, waveform and duration.
        for (int i = 0; i < 10; i++) begin
            gate_sel = 2'($urandom_range(0, 3));
            fx_mode  = $urandom_range(0, 2);
            fx_per   = $urandom_range(4, 12);
            fx_level = 1'($urandom_range(0, 1));
            run($urandom_range(100, 2500));
        end

        // Fxin held low across several short windows.
        gate_sel = 2'd1; fx_mode = 0; fx_level = 1'b0;
        run(GATE_CYCLES + 4 * 200);

        // Let any outstanding publication appear.
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
